// File: rtl/l1_collector.sv
// l1_collector
//   Receive-side L1 signalling extractor. Walks a delineated T2-MI byte stream,
//   accepts packets of type PKT_TYPE, skips the 6-byte header plus L1_OFFSET
//   payload bytes, and captures the next L1_LEN_BYTES bytes into a shadow
//   register. A complete capture is published on L1_BUS (byte i on [8i+7:8i]).
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   DATA_IN, ENA_IN     stream byte and its valid strobe
//   PSTART              byte 0 of a packet (only meaningful with ENA_IN)
//   L1_BUS              last good L1 block
//   L1_VALID            1-cycle pulse, L1_BUS just updated
//   L1_CHANGED          1-cycle pulse with L1_VALID when the block differs
//   L1_ERR              1-cycle pulse, accepted packet aborted or too short
//   L1_COUNT            number of L1_VALID pulses, wrapping
module l1_collector #(
  parameter int          L1_LEN_BYTES = 32,
  parameter int          L1_OFFSET    = 2,
  parameter logic [7:0]  PKT_TYPE     = 8'h10
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [7:0]                DATA_IN,
  input  logic                      ENA_IN,
  input  logic                      PSTART,
  output logic [8*L1_LEN_BYTES-1:0] L1_BUS,
  output logic                      L1_VALID,
  output logic                      L1_CHANGED,
  output logic                      L1_ERR,
  output logic [15:0]               L1_COUNT
);
  localparam int          BW        = 8*L1_LEN_BYTES;
  localparam int          CW        = $clog2(L1_LEN_BYTES + L1_OFFSET + 8);
  localparam int          SKIP_LAST = (L1_OFFSET > 0) ? L1_OFFSET - 1 : 0;
  localparam logic [16:0] MIN_BITS  = 17'(8*(L1_OFFSET + L1_LEN_BYTES));

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SKIP, S_CAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [BW-1:0]    shadow_q, shadow_d;
  logic [BW-1:0]    bus_q, bus_d;
  logic             vld_q, vld_d, chg_q, chg_d, err_q, err_d;
  logic [15:0]      count_q, count_d;

  logic sof, type_ok, busy, len_ok, cap_last;
  assign sof      = PSTART & ENA_IN;
  assign type_ok  = (DATA_IN == PKT_TYPE);
  assign busy     = (state_q == S_HDR) || (state_q == S_SKIP) || (state_q == S_CAP);
  // byte 5 completes payload_len; compare using the live low byte
  assign len_ok   = ({1'b0, len_hi_q, DATA_IN} >= MIN_BITS);
  assign cap_last = (cnt_q == CW'(L1_LEN_BYTES - 1));

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_hi_q <= '0;
      shadow_q <= '0;
      bus_q    <= '0;
      vld_q    <= 1'b0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_hi_q <= len_hi_d;
      shadow_q <= shadow_d;
      bus_q    <= bus_d;
      vld_q    <= vld_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sof) begin
      // PSTART always restarts parsing, whatever state we were in
      state_d = type_ok ? S_HDR : S_IDLE;
      cnt_d   = CW'(1);
    end else begin
      case (state_q)
        S_HDR: if (ENA_IN) begin
          if (cnt_q == CW'(5)) begin
            state_d = len_ok ? ((L1_OFFSET == 0) ? S_CAP : S_SKIP) : S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SKIP: if (ENA_IN) begin
          if (cnt_q == CW'(SKIP_LAST)) begin
            state_d = S_CAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CAP: if (ENA_IN) begin
          if (cap_last) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs / datapath
  always_comb begin
    len_hi_d = len_hi_q;
    shadow_d = shadow_q;
    bus_d    = bus_q;
    vld_d    = 1'b0;
    chg_d    = 1'b0;
    err_d    = 1'b0;
    count_d  = count_q;
    if (sof) begin
      err_d = busy;
    end else if (ENA_IN) begin
      if (state_q == S_HDR) begin
        if (cnt_q == CW'(4)) len_hi_d = DATA_IN;
        if (cnt_q == CW'(5) && !len_ok) err_d = 1'b1;
      end
      if (state_q == S_CAP) begin
        shadow_d[8*int'(cnt_q) +: 8] = DATA_IN;
        // publish on the edge taking the last byte so L1_VALID lands
        // in the DONE cycle together with the new bus value
        if (cap_last) begin
          bus_d   = shadow_d;
          vld_d   = 1'b1;
          chg_d   = (shadow_d != bus_q);
          count_d = count_q + 16'd1;
        end
      end
    end
  end

  assign L1_BUS     = bus_q;
  assign L1_VALID   = vld_q;
  assign L1_CHANGED = chg_q;
  assign L1_ERR     = err_q;
  assign L1_COUNT   = count_q;
endmodule

// File: tb/tb_l1_collector.sv
module tb_l1_collector;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [7:0]   DATA_IN = '0;
  logic         ENA_IN = 1'b0;
  logic         PSTART = 1'b0;
  logic [255:0] L1_BUS;
  logic         L1_VALID, L1_CHANGED, L1_ERR;
  logic [15:0]  L1_COUNT;

  l1_collector dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .PSTART(PSTART),
    .L1_BUS(L1_BUS), .L1_VALID(L1_VALID), .L1_CHANGED(L1_CHANGED),
    .L1_ERR(L1_ERR), .L1_COUNT(L1_COUNT)
  );

  always #5 CLK = ~CLK;

  int nvec = 0, nerr = 0;
  int vld_n = 0, chg_n = 0, err_n = 0;
  logic [7:0]   pkt [0:43];
  logic [255:0] exp_bus;

  always @(negedge CLK) begin
    if (L1_VALID)   vld_n++;
    if (L1_CHANGED) chg_n++;
    if (L1_ERR)     err_n++;
  end

  task automatic drive_byte(input logic [7:0] b, input logic ps, input logic en);
    @(negedge CLK);
    DATA_IN = b; PSTART = ps; ENA_IN = en;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_byte(8'h00, 1'b0, 1'b0);
  endtask

  task automatic mk_exp();
    for (int k = 0; k < 32; k++) exp_bus[8*k +: 8] = pkt[8+k];
  endtask

  task automatic build(input logic [7:0] typ, input logic [15:0] len, input logic [7:0] seed);
    pkt[0] = typ; pkt[1] = 8'h01; pkt[2] = 8'h00; pkt[3] = 8'h00;
    pkt[4] = len[15:8]; pkt[5] = len[7:0]; pkt[6] = 8'h03; pkt[7] = 8'h00;
    for (int k = 0; k < 32; k++) pkt[8+k] = seed + 8'(k);
    for (int k = 40; k < 44; k++) pkt[k] = 8'hC0 + 8'(k);
    mk_exp();
  endtask

  // bytes [from, to); random idles carry PSTART noise with ENA_IN low
  task automatic send_range(input int from, input int to, input bit rnd);
    for (int i = from; i < to; i++) begin
      if (rnd) while ($urandom_range(0, 1) == 0) drive_byte(8'(($urandom)), 1'($urandom), 1'b0);
      drive_byte(pkt[i], i == 0, 1'b1);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    nvec++; if (L1_BUS !== '0) begin nerr++; $display("FAIL reset_bus got %h want 0", L1_BUS); end
    nvec++; if (L1_VALID !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", L1_VALID); end
    nvec++; if (L1_CHANGED !== 1'b0) begin nerr++; $display("FAIL reset_changed got %b want 0", L1_CHANGED); end
    nvec++; if (L1_ERR !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", L1_ERR); end
    nvec++; if (L1_COUNT !== 16'h0) begin nerr++; $display("FAIL reset_count got %h want 0", L1_COUNT); end
    @(negedge CLK); RST = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    build(8'h10, 16'h0110, 8'h00);
    send_range(0, 39, 0);
    nvec++; if (L1_VALID !== 1'b0) begin nerr++; $display("FAIL basic_early_valid got %b want 0", L1_VALID); end
    drive_byte(pkt[39], 1'b0, 1'b1);
    nvec++; if (L1_VALID !== 1'b1) begin nerr++; $display("FAIL basic_latency got %b want 1", L1_VALID); end
    send_range(40, 44, 0);
    idle(2);
    nvec++; if (L1_BUS[7:0] !== 8'h00) begin nerr++; $display("FAIL basic_byte0 got %h want 00", L1_BUS[7:0]); end
    nvec++; if (L1_BUS[255:248] !== 8'h1F) begin nerr++; $display("FAIL basic_byte31 got %h want 1f", L1_BUS[255:248]); end
    nvec++; if (L1_BUS !== exp_bus) begin nerr++; $display("FAIL basic_bus got %h want %h", L1_BUS, exp_bus); end
    nvec++; if (L1_COUNT !== 16'd1) begin nerr++; $display("FAIL basic_count got %0d want 1", L1_COUNT); end
    nvec++; if (vld_n !== 1) begin nerr++; $display("FAIL basic_vld_pulses got %0d want 1", vld_n); end
    nvec++; if (chg_n !== 1) begin nerr++; $display("FAIL basic_changed got %0d want 1", chg_n); end
    nvec++; if (err_n !== 0) begin nerr++; $display("FAIL basic_err got %0d want 0", err_n); end
  endtask

  task automatic test_repeat();
    int c0;
    c0 = chg_n;
    build(8'h10, 16'h0110, 8'h00);
    send_range(0, 44, 0); idle(2);
    nvec++; if (chg_n !== c0) begin nerr++; $display("FAIL repeat_changed got %0d want %0d", chg_n, c0); end
    nvec++; if (L1_COUNT !== 16'd2) begin nerr++; $display("FAIL repeat_count got %0d want 2", L1_COUNT); end
    pkt[13] = 8'hAA; mk_exp();
    send_range(0, 44, 0); idle(2);
    nvec++; if (chg_n !== c0 + 1) begin nerr++; $display("FAIL repeat_byte5_changed got %0d want %0d", chg_n, c0 + 1); end
    nvec++; if (L1_BUS[47:40] !== 8'hAA) begin nerr++; $display("FAIL repeat_byte5 got %h want aa", L1_BUS[47:40]); end
    nvec++; if (L1_COUNT !== 16'd3) begin nerr++; $display("FAIL repeat_count2 got %0d want 3", L1_COUNT); end
  endtask

  task automatic test_other_type();
    int v0, e0;
    logic [255:0] held;
    v0 = vld_n; e0 = err_n; held = L1_BUS;
    build(8'h00, 16'h0110, 8'h99);
    send_range(0, 44, 0); idle(2);
    nvec++; if (vld_n !== v0) begin nerr++; $display("FAIL bbframe_valid got %0d want %0d", vld_n, v0); end
    nvec++; if (err_n !== e0) begin nerr++; $display("FAIL bbframe_err got %0d want %0d", err_n, e0); end
    nvec++; if (L1_BUS !== held) begin nerr++; $display("FAIL bbframe_bus got %h want %h", L1_BUS, held); end
  endtask

  task automatic test_short();
    int v0, e0;
    logic [255:0] held;
    v0 = vld_n; e0 = err_n; held = L1_BUS;
    build(8'h10, 16'h0100, 8'h07);
    send_range(0, 6, 0);
    nvec++; if (L1_ERR !== 1'b1) begin nerr++; $display("FAIL short_err_pulse got %b want 1", L1_ERR); end
    drive_byte(pkt[6], 1'b0, 1'b1);
    nvec++; if (L1_ERR !== 1'b0) begin nerr++; $display("FAIL short_err_width got %b want 0", L1_ERR); end
    send_range(7, 44, 0); idle(2);
    nvec++; if (err_n !== e0 + 1) begin nerr++; $display("FAIL short_err_count got %0d want %0d", err_n, e0 + 1); end
    nvec++; if (vld_n !== v0) begin nerr++; $display("FAIL short_valid got %0d want %0d", vld_n, v0); end
    nvec++; if (L1_BUS !== held) begin nerr++; $display("FAIL short_bus got %h want %h", L1_BUS, held); end
  endtask

  task automatic test_abort();
    int v0, e0, c0;
    v0 = vld_n; e0 = err_n;
    build(8'h10, 16'h0110, 8'h40);
    send_range(0, 18, 0);           // header, skip, capture bytes 0..9
    build(8'h10, 16'h0110, 8'h80);
    drive_byte(pkt[0], 1'b1, 1'b1);  // restart at capture byte 10
    nvec++; if (L1_ERR !== 1'b1) begin nerr++; $display("FAIL abort_err got %b want 1", L1_ERR); end
    send_range(1, 44, 0); idle(2);
    nvec++; if (L1_BUS !== exp_bus) begin nerr++; $display("FAIL abort_bus got %h want %h", L1_BUS, exp_bus); end
    nvec++; if (err_n !== e0 + 1) begin nerr++; $display("FAIL abort_err_count got %0d want %0d", err_n, e0 + 1); end
    nvec++; if (vld_n !== v0 + 1) begin nerr++; $display("FAIL abort_valid got %0d want %0d", vld_n, v0 + 1); end
    c0 = chg_n;
    send_range(0, 44, 1); idle(3);
    nvec++; if (L1_BUS !== exp_bus) begin nerr++; $display("FAIL randena_bus got %h want %h", L1_BUS, exp_bus); end
    nvec++; if (chg_n !== c0) begin nerr++; $display("FAIL randena_changed got %0d want %0d", chg_n, c0); end
    nvec++; if (L1_COUNT !== 16'd5) begin nerr++; $display("FAIL randena_count got %0d want 5", L1_COUNT); end
    nvec++; if (err_n !== e0 + 1) begin nerr++; $display("FAIL randena_err got %0d want %0d", err_n, e0 + 1); end
  endtask

  task automatic test_reset_mid();
    build(8'h10, 16'h0110, 8'h20);
    send_range(0, 26, 0);
    RST = 1'b1;
    #1;
    nvec++; if (L1_BUS !== '0) begin nerr++; $display("FAIL rstmid_bus got %h want 0", L1_BUS); end
    nvec++; if (L1_COUNT !== 16'h0) begin nerr++; $display("FAIL rstmid_count got %h want 0", L1_COUNT); end
    nvec++; if ({L1_VALID, L1_CHANGED, L1_ERR} !== 3'b000) begin nerr++; $display("FAIL rstmid_pulses got %b want 000", {L1_VALID, L1_CHANGED, L1_ERR}); end
    @(negedge CLK); RST = 1'b0;
    idle(2);
    send_range(26, 44, 0);          // leftover bytes of the killed packet: ignored
    idle(2);
    nvec++; if (L1_COUNT !== 16'h0) begin nerr++; $display("FAIL rstmid_leftover got %0d want 0", L1_COUNT); end
    send_range(0, 44, 0); idle(2);
    nvec++; if (L1_BUS !== exp_bus) begin nerr++; $display("FAIL rstmid_recap got %h want %h", L1_BUS, exp_bus); end
    nvec++; if (L1_COUNT !== 16'd1) begin nerr++; $display("FAIL rstmid_recount got %0d want 1", L1_COUNT); end
  endtask

  task automatic test_wrap();
    @(negedge CLK);
    force dut.count_q = 16'hFFFE;
    @(posedge CLK); #1;
    release dut.count_q;
    idle(1);
    build(8'h10, 16'h0110, 8'h01);
    send_range(0, 44, 0); idle(2);
    nvec++; if (L1_COUNT !== 16'hFFFF) begin nerr++; $display("FAIL wrap_ffff got %h want ffff", L1_COUNT); end
    build(8'h10, 16'h0110, 8'h02);
    send_range(0, 44, 0); idle(2);
    nvec++; if (L1_COUNT !== 16'h0000) begin nerr++; $display("FAIL wrap_zero got %h want 0000", L1_COUNT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_other_type();
    test_short();
    test_abort();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
